// File: rtl/store_control_sequencer.sv
// Control sequencer for the store instruction st Ra, C(Rb): fetch, address add, then M[Rb+C] <= Ra.
// Strobes decode from the state register and wait counter only; T1/T7 wait on mem_ready with a timeout.
module store_control_sequencer #(
  parameter logic [4:0] ST_OPCODE   = 5'b00010,
  parameter logic [4:0] ADD_OPCODE  = 5'b00000,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_mem_ready,
  input  logic [4:0] i_ir_opcode,
  output logic       o_PC_select,
  output logic       o_MAR_enable,
  output logic       o_PC_increment_enable,
  output logic       o_read,
  output logic       o_write,
  output logic       o_MDR_enable,
  output logic       o_MDR_select,
  output logic       o_IR_enable,
  output logic       o_Gra,
  output logic       o_Grb,
  output logic       o_Rout,
  output logic       o_BAout,
  output logic       o_Y_enable,
  output logic       o_Z_enable,
  output logic       o_c_select,
  output logic       o_Z_LO_select,
  output logic [4:0] o_alu_instruction,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [3:0] o_state_out
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0000,
    S_ERROR = 4'b0001,
    S_T0    = 4'b0111,
    S_T1    = 4'b1000,
    S_T2    = 4'b1001,
    S_T3    = 4'b1010,
    S_T4    = 4'b1011,
    S_T5    = 4'b1100,
    S_T6    = 4'b1101,
    S_T7    = 4'b1110,
    S_DONE  = 4'b1111
  } state_t;

  // Last wait_cnt value allowed before a missing mem_ready becomes a timeout.
  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;

  // State register and wait counter; counter restarts on every state change.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_wait_cnt <= 8'd0;
      end else if ((r_state == S_T1) || (r_state == S_T7)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_next_state = S_T0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_T0: w_next_state = S_T1;
      S_T1: begin
        if (i_mem_ready) begin
          w_next_state = S_T2;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_next_state = S_ERROR;
        end else begin
          w_next_state = S_T1;
        end
      end
      S_T2: w_next_state = S_T3;
      S_T3: begin
        if (i_ir_opcode == ST_OPCODE) begin
          w_next_state = S_T4;
        end else begin
          w_next_state = S_ERROR;
        end
      end
      S_T4: w_next_state = S_T5;
      S_T5: w_next_state = S_T6;
      S_T6: w_next_state = S_T7;
      S_T7: begin
        if (i_mem_ready) begin
          w_next_state = S_DONE;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_next_state = S_ERROR;
        end else begin
          w_next_state = S_T7;
        end
      end
      S_ERROR: w_next_state = S_ERROR;
      // Unused encodings are treated as a fault.
      default: w_next_state = S_ERROR;
    endcase
  end

  // Output decode from state and wait counter.
  always_comb begin
    o_PC_select           = 1'b0;
    o_MAR_enable          = 1'b0;
    o_PC_increment_enable = 1'b0;
    o_read                = 1'b0;
    o_write               = 1'b0;
    o_MDR_enable          = 1'b0;
    o_MDR_select          = 1'b0;
    o_IR_enable           = 1'b0;
    o_Gra                 = 1'b0;
    o_Grb                 = 1'b0;
    o_Rout                = 1'b0;
    o_BAout               = 1'b0;
    o_Y_enable            = 1'b0;
    o_Z_enable            = 1'b0;
    o_c_select            = 1'b0;
    o_Z_LO_select         = 1'b0;
    o_alu_instruction     = 5'b00000;
    o_busy                = 1'b0;
    o_done                = 1'b0;
    o_error               = 1'b0;
    case (r_state)
      S_T0: begin
        o_busy       = 1'b1;
        o_PC_select  = 1'b1;
        o_MAR_enable = 1'b1;
      end
      S_T1: begin
        o_busy                = 1'b1;
        o_read                = 1'b1;
        o_MDR_enable          = 1'b1;
        // Only the first T1 cycle increments, however long the fetch stalls.
        o_PC_increment_enable = (r_wait_cnt == 8'd0);
      end
      S_T2: begin
        o_busy       = 1'b1;
        o_MDR_select = 1'b1;
        o_IR_enable  = 1'b1;
      end
      S_T3: begin
        o_busy     = 1'b1;
        o_Grb      = 1'b1;
        o_BAout    = 1'b1;
        o_Y_enable = 1'b1;
      end
      S_T4: begin
        o_busy            = 1'b1;
        o_c_select        = 1'b1;
        o_Z_enable        = 1'b1;
        o_alu_instruction = ADD_OPCODE;
      end
      S_T5: begin
        o_busy        = 1'b1;
        o_Z_LO_select = 1'b1;
        o_MAR_enable  = 1'b1;
      end
      S_T6: begin
        o_busy       = 1'b1;
        o_Gra        = 1'b1;
        o_Rout       = 1'b1;
        o_MDR_enable = 1'b1;
      end
      S_T7: begin
        o_busy  = 1'b1;
        o_write = 1'b1;
      end
      S_DONE:  o_done  = 1'b1;
      S_ERROR: o_error = 1'b1;
      default: o_error = 1'b0;
    endcase
  end

  assign o_state_out = r_state;

endmodule

// File: tb/tb_store_control_sequencer.sv
// Directed bench for store_control_sequencer: a phase-level model is compared every cycle,
// and hand-computed literal expectations pin the model and the sequence timing.
module tb_store_control_sequencer;

  localparam int MEM_TO = 15;

  logic       clk = 1'b0;
  logic       reset, start, mem_ready;
  logic [4:0] opc;
  logic       pc_sel, mar_en, pc_inc, rd, wr, mdr_en, mdr_sel, ir_en;
  logic       gra, grb, rout, baout, y_en, z_en, c_sel, zlo_sel;
  logic [4:0] alu;
  logic       busy, done, error;
  logic [3:0] state_out;

  store_control_sequencer #(.MEM_TIMEOUT(MEM_TO)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mem_ready(mem_ready), .i_ir_opcode(opc),
    .o_PC_select(pc_sel), .o_MAR_enable(mar_en), .o_PC_increment_enable(pc_inc),
    .o_read(rd), .o_write(wr), .o_MDR_enable(mdr_en), .o_MDR_select(mdr_sel),
    .o_IR_enable(ir_en), .o_Gra(gra), .o_Grb(grb), .o_Rout(rout), .o_BAout(baout),
    .o_Y_enable(y_en), .o_Z_enable(z_en), .o_c_select(c_sel), .o_Z_LO_select(zlo_sel),
    .o_alu_instruction(alu), .o_busy(busy), .o_done(done), .o_error(error),
    .o_state_out(state_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  // Model: phase -1 idle, 0..7 = T0..T7, 8 done, 9 error; spent = cycles already waited.
  int m_ph    = -1;
  int m_spent = 0;

  logic [27:0] w_dut;
  assign w_dut = {state_out, pc_sel, mar_en, pc_inc, rd, wr, mdr_en, mdr_sel, ir_en,
                  gra, grb, rout, baout, y_en, z_en, c_sel, zlo_sel, alu, busy, done, error};

  function automatic logic [27:0] model_out(input int ph, input int sp);
    logic [3:0] st;
    logic [15:0] s;
    logic [4:0] a;
    logic b, d, e;
    s = 16'h0000; a = 5'b00000; b = 1'b0; d = 1'b0; e = 1'b0;
    if (ph == -1) st = 4'd0;
    else if (ph == 9) begin st = 4'd1; e = 1'b1; end
    else st = 4'(7 + ph);
    b = (ph >= 0) && (ph <= 7);
    d = (ph == 8);
    // s bit order: pcs mar pci rd wr mdre mdrs ire gra grb rout ba ye ze cs zlo (MSB first)
    case (ph)
      0: begin s[15] = 1'b1; s[14] = 1'b1; end
      1: begin s[12] = 1'b1; s[10] = 1'b1; s[13] = (sp == 0); end
      2: begin s[9] = 1'b1; s[8] = 1'b1; end
      3: begin s[6] = 1'b1; s[4] = 1'b1; s[3] = 1'b1; end
      4: begin s[1] = 1'b1; s[2] = 1'b1; a = 5'b00000; end
      5: begin s[0] = 1'b1; s[14] = 1'b1; end
      6: begin s[7] = 1'b1; s[5] = 1'b1; s[10] = 1'b1; end
      7: s[11] = 1'b1;
      default: s = 16'h0000;
    endcase
    return {st, s, a, b, d, e};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph <= -1; m_spent <= 0;
    end else begin
      case (m_ph)
        -1, 8: begin m_ph <= start ? 0 : -1; m_spent <= 0; end
        1, 7: begin
          if (mem_ready) begin m_ph <= (m_ph == 1) ? 2 : 8; m_spent <= 0; end
          else if (m_spent + 1 >= MEM_TO) m_ph <= 9;
          else m_spent <= m_spent + 1;
        end
        3: m_ph <= (opc == 5'b00010) ? 4 : 9;
        9: m_ph <= 9;
        default: m_ph <= m_ph + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (w_dut !== model_out(m_ph, m_spent)) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, w_dut, model_out(m_ph, m_spent));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input int code, input int budget);
    int n = 0;
    while (int'(state_out) != code && n < budget) begin tick(); n++; end
    chk("wait_state_reached", int'(state_out), code);
  endtask

  // Entered at a negedge in T0; leaves at the negedge after DONE.
  task automatic check_nominal(input string tag);
    int exp_seq[9] = '{7, 8, 9, 10, 11, 12, 13, 14, 15};
    int npci = 0, ndone = 0, nwr = 0, nalu4 = 0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s_state_%0d", tag, i), int'(state_out), exp_seq[i]);
      npci  += int'(pc_inc);
      ndone += int'(done);
      nwr   += int'(wr);
      if (wr) chk({tag, "_write_in_T7"}, int'(state_out), 14);
      if (z_en) nalu4++;
      tick();
    end
    chk({tag, "_pc_inc_cycles"}, npci, 1);
    chk({tag, "_done_cycles"}, ndone, 1);
    chk({tag, "_write_cycles"}, nwr, 1);
    chk({tag, "_alu_add_cycles"}, nalu4, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nze, nwr, nmar5;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1; opc = 5'b00010;
    tick(); cmp_en = 1'b1;
    tick(); tick();
    chk("reset_state", int'(state_out), 0);
    chk("reset_outputs", int'(w_dut), 0);
    reset = 1'b0;

    // 1: nominal sequence
    tick(); start = 1'b1; tick(); start = 1'b0;
    check_nominal("t1");
    chk("t1_idle_after_done", int'(state_out), 0);

    // 2: fetch stalls three cycles
    mem_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t2_in_T1_%0d", k), int'(state_out), 8);
      chk($sformatf("t2_pc_inc_%0d", k), int'(pc_inc), (k == 1) ? 1 : 0);
      chk($sformatf("t2_read_%0d", k), int'(rd & mdr_en), 1);
      if (k == 4) mem_ready = 1'b1;
    end
    tick();
    chk("t2_reached_T2", int'(state_out), 9);
    wait_state(0, 20);

    // 3: write never acknowledged -> timeout
    start = 1'b1; tick(); start = 1'b0;
    wait_state(14, 20);
    mem_ready = 1'b0;
    n = 1;
    while (int'(state_out) == 14 && n < 40) begin
      tick();
      if (int'(state_out) == 14) n++;
    end
    chk("t3_T7_cycles", n, 15);
    chk("t3_error_state", int'(state_out), 1);
    chk("t3_error_flag", int'(error), 1);
    chk("t3_write_low", int'(wr), 0);
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    chk("t3_start_ignored", int'(state_out), 1);
    reset = 1'b1; tick(); reset = 1'b0; mem_ready = 1'b1;
    chk("t3_reset_clears", int'(state_out), 0);

    // 4: bad opcode at T3
    opc = 5'b00000; start = 1'b1; tick(); start = 1'b0;
    nze = 0; nwr = 0; nmar5 = 0;
    for (int i = 0; i <= 6; i++) begin
      if (i == 4) chk("t4_error_after_T3", int'(state_out), 1);
      nze += int'(z_en);
      nwr += int'(wr);
      if (int'(state_out) == 12) nmar5 += int'(mar_en);
      tick();
    end
    chk("t4_no_z_enable", nze, 0);
    chk("t4_no_write", nwr, 0);
    chk("t4_no_t5_mar", nmar5, 0);
    reset = 1'b1; tick(); reset = 1'b0; opc = 5'b00010;

    // 5: start during T2 ignored, reset in T5
    start = 1'b1; tick(); start = 1'b0;
    wait_state(9, 5);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_no_restart", int'(state_out), 10);
    wait_state(12, 10);
    reset = 1'b1; tick();
    chk("t5_reset_state", int'(state_out), 0);
    chk("t5_reset_outputs", int'(w_dut), 0);
    reset = 1'b0;

    // 6: start held through DONE -> back-to-back
    start = 1'b1; tick();
    check_nominal("t6a");
    chk("t6_back_to_back_T0", int'(state_out), 7);
    start = 1'b0;
    check_nominal("t6b");
    chk("t6_idle_after_done", int'(state_out), 0);

    tick();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
